// File: rtl/ball_physics_de1soc_if.sv
// Signal bundle between the ball engine and its neighbours: frame/serve/paddle in,
// ball position, lives and event pulses out.
interface ball_physics_de1soc_if;
  logic        frame_tick;
  logic        serve;
  logic [15:0] paddle_x;
  logic [15:0] paddle_y;
  logic [15:0] ball_x;
  logic [15:0] ball_y;
  logic [2:0]  lives;
  logic        hit;
  logic        miss;
  logic        game_over;

  modport master (
    output frame_tick, serve, paddle_x, paddle_y,
    input  ball_x, ball_y, lives, hit, miss, game_over
  );

  modport slave (
    input  frame_tick, serve, paddle_x, paddle_y,
    output ball_x, ball_y, lives, hit, miss, game_over
  );
endinterface

// File: rtl/ball_physics_de1soc.sv
// Breakout ball engine: steps the ball once per frame, reflects it off walls,
// ceiling and paddle, and tracks misses and lives.
//
// state | meaning
// IDLE  | ball parked on the paddle, waiting for serve
// PLAY  | ball moving, one step per frame_tick
// MISS  | ball lost, waiting SERVE_FRAMES frames before re-parking
// OVER  | no lives left, waiting for serve to restart
module ball_physics_de1soc #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int BALL_SIZE     = 8,
  parameter int PADDLE_WIDTH  = 64,
  parameter int SPEED_X       = 2,
  parameter int SPEED_Y       = 2,
  parameter int LIVES         = 3,
  parameter int SERVE_FRAMES  = 60
) (
  input logic                    clk,
  input logic                    rst,
  ball_physics_de1soc_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_MISS, S_OVER} state_t;

  localparam int CNT_W = $clog2(SERVE_FRAMES) + 1;
  localparam logic signed [17:0] ZERO  = '0;
  localparam logic signed [17:0] BS    = 18'(BALL_SIZE);
  localparam logic signed [17:0] HBS   = 18'(BALL_SIZE / 2);
  localparam logic signed [17:0] PW    = 18'(PADDLE_WIDTH);
  localparam logic signed [17:0] HPW   = 18'(PADDLE_WIDTH / 2);
  localparam logic signed [17:0] SX    = 18'(SPEED_X);
  localparam logic signed [17:0] SY    = 18'(SPEED_Y);
  localparam logic signed [17:0] X_MAX = 18'(SCREEN_WIDTH - BALL_SIZE);
  localparam logic signed [17:0] Y_MAX = 18'(SCREEN_HEIGHT - BALL_SIZE);

  state_t           state_q, state_d;
  logic [15:0]      ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic             vx_neg_q, vx_neg_d, vy_neg_q, vy_neg_d;
  logic [2:0]       lives_q, lives_d;
  logic             hit_q, hit_d, miss_q, miss_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic signed [17:0] bx, by, px, py, vx, vy, nx, ny;
  logic [15:0]        x_next;
  logic               vxn_next;
  logic               paddle_hit;

  always_comb begin
    bx = $signed({2'b00, ball_x_q});
    by = $signed({2'b00, ball_y_q});
    px = $signed({2'b00, bus.paddle_x});
    py = $signed({2'b00, bus.paddle_y});
    vx = vx_neg_q ? -SX : SX;
    vy = vy_neg_q ? -SY : SY;
    nx = bx + vx;
    ny = by + vy;
    paddle_hit = !vy_neg_q && (by + BS <= py) && (ny + BS >= py) &&
                 (bx + BS > px) && (bx < px + PW);

    x_next   = nx[15:0];
    vxn_next = vx_neg_q;
    if (nx <= ZERO) begin
      x_next   = '0;
      vxn_next = 1'b0;
    end else if (nx >= X_MAX) begin
      x_next   = X_MAX[15:0];
      vxn_next = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    vx_neg_d = vx_neg_q;
    vy_neg_d = vy_neg_q;
    lives_d  = lives_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        ball_x_d = bus.paddle_x + 16'(PADDLE_WIDTH / 2 - BALL_SIZE / 2);
        ball_y_d = bus.paddle_y - 16'(BALL_SIZE);
        if (bus.serve) begin
          state_d  = S_PLAY;
          vx_neg_d = 1'b0;
          vy_neg_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (bus.frame_tick) begin
          if (ny <= ZERO) begin
            ball_x_d = x_next;
            vx_neg_d = vxn_next;
            ball_y_d = '0;
            vy_neg_d = 1'b0;
          end else if (paddle_hit) begin
            // Bounce direction follows which half of the paddle was struck.
            ball_x_d = x_next;
            vx_neg_d = (bx + HBS < px + HPW);
            ball_y_d = bus.paddle_y - 16'(BALL_SIZE);
            vy_neg_d = 1'b1;
            hit_d    = 1'b1;
          end else if (ny >= Y_MAX) begin
            miss_d  = 1'b1;
            lives_d = lives_q - 3'd1;
            if (lives_q == 3'd1) begin
              state_d = S_OVER;
            end else begin
              state_d = S_MISS;
              cnt_d   = CNT_W'(SERVE_FRAMES - 1);
            end
          end else begin
            ball_x_d = x_next;
            vx_neg_d = vxn_next;
            ball_y_d = ny[15:0];
          end
        end
      end
      S_MISS: begin
        if (bus.frame_tick) begin
          if (cnt_q == '0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_OVER: begin
        if (bus.serve) begin
          state_d = S_IDLE;
          lives_d = 3'(LIVES);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ball_x_q <= '0;
      ball_y_q <= '0;
      vx_neg_q <= 1'b0;
      vy_neg_q <= 1'b1;
      lives_q  <= 3'(LIVES);
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      vx_neg_q <= vx_neg_d;
      vy_neg_q <= vy_neg_d;
      lives_q  <= lives_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.ball_x    = ball_x_q;
  assign bus.ball_y    = ball_y_q;
  assign bus.lives     = lives_q;
  assign bus.hit       = hit_q;
  assign bus.miss      = miss_q;
  assign bus.game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_ball_physics_de1soc.sv
// Bench for the breakout ball engine: integer game model checked every cycle,
// plus directed scenarios with hand-computed positions.
module tb_ball_physics_de1soc;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  ball_physics_de1soc_if ifc ();
  ball_physics_de1soc dut (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  // Game model: mode 0 idle, 1 play, 2 miss wait, 3 over.
  int m_x, m_y, m_vx, m_vy, m_lives, m_mode, m_frames;
  bit m_hit, m_miss, m_valid = 1'b0;

  always @(posedge clk) begin
    int px, py, nx, ny, fx, fy, fvx, fvy;
    px = int'(ifc.paddle_x);
    py = int'(ifc.paddle_y);
    m_hit  = 1'b0;
    m_miss = 1'b0;
    if (rst) begin
      m_valid = 1'b1;
      m_mode = 0; m_x = 0; m_y = 0; m_vx = 2; m_vy = -2;
      m_lives = 3; m_frames = 0;
    end else begin
      case (m_mode)
        0: begin
          m_x = (px + 28) & 'hFFFF;
          m_y = (py - 8) & 'hFFFF;
          if (ifc.serve) begin m_mode = 1; m_vx = 2; m_vy = -2; end
        end
        1: if (ifc.frame_tick) begin
          nx = m_x + m_vx; ny = m_y + m_vy;
          fx = nx; fvx = m_vx; fy = ny; fvy = m_vy;
          if (nx <= 0) begin fx = 0; fvx = 2; end
          else if (nx >= 632) begin fx = 632; fvx = -2; end
          if (ny <= 0) begin fy = 0; fvy = 2; end
          else if (m_vy > 0 && m_y + 8 <= py && ny + 8 >= py &&
                   m_x + 8 > px && m_x < px + 64) begin
            fy = py - 8; fvy = -2; m_hit = 1'b1;
            fvx = (m_x + 4 < px + 32) ? -2 : 2;
          end else if (ny >= 472) begin
            m_miss = 1'b1;
            m_lives = m_lives - 1;
            m_mode = (m_lives == 0) ? 3 : 2;
            m_frames = 0;
          end
          if (!m_miss) begin m_x = fx; m_y = fy; m_vx = fvx; m_vy = fvy; end
        end
        2: if (ifc.frame_tick) begin
          m_frames++;
          if (m_frames == 60) begin m_frames = 0; m_mode = 0; end
        end
        default: if (ifc.serve) begin m_mode = 0; m_lives = 3; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      n_vec++;
      if (ifc.ball_x !== 16'(m_x) || ifc.ball_y !== 16'(m_y) ||
          ifc.lives !== 3'(m_lives) || ifc.hit !== m_hit || ifc.miss !== m_miss ||
          ifc.game_over !== (m_mode == 3)) begin
        n_err++;
        $display("FAIL model t=%0t: got x=%0d y=%0d lives=%0d hit=%0b miss=%0b over=%0b expected x=%0d y=%0d lives=%0d hit=%0b miss=%0b over=%0b",
                 $time, ifc.ball_x, ifc.ball_y, ifc.lives, ifc.hit, ifc.miss, ifc.game_over,
                 m_x, m_y, m_lives, m_hit, m_miss, (m_mode == 3));
      end
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle(input bit t, input bit s);
    @(negedge clk);
    ifc.frame_tick = t;
    ifc.serve      = s;
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin cycle(1'b1, 1'b0); cycle(1'b0, 1'b0); end
  endtask

  task automatic wait_miss(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      cycle(1'b1, 1'b0);
      got = ifc.miss;
      if (!got) cycle(1'b0, 1'b0);
    end
    lit({name, "_seen"}, int'(got), 1);
  endtask

  initial begin
    rst = 1'b1;
    ifc.frame_tick = 1'b0; ifc.serve = 1'b0;
    ifc.paddle_x = 16'd288; ifc.paddle_y = 16'd440;
    cycle(0, 0); cycle(0, 0);
    lit("rst_x", ifc.ball_x, 0);
    lit("rst_y", ifc.ball_y, 0);
    lit("rst_lives", ifc.lives, 3);
    lit("rst_over", ifc.game_over, 0);
    rst = 1'b0;
    cycle(0, 0);
    lit("idle_x", ifc.ball_x, 316);
    lit("idle_y", ifc.ball_y, 432);

    cycle(1, 1);
    lit("serve_tick_x", ifc.ball_x, 316);
    lit("serve_tick_y", ifc.ball_y, 432);
    cycle(0, 0);
    cycle(1, 0);
    lit("step1_x", ifc.ball_x, 318);
    lit("step1_y", ifc.ball_y, 430);
    cycle(0, 0);

    ifc.paddle_x = 16'd56;
    frames(156);
    lit("wall_pre_x", ifc.ball_x, 630);
    frames(1);
    lit("wall_clamp_x", ifc.ball_x, 632);
    frames(1);
    lit("wall_back_x", ifc.ball_x, 630);

    frames(272);
    lit("pre_hit_x", ifc.ball_x, 86);
    lit("pre_hit_y", ifc.ball_y, 430);
    cycle(1, 0);
    lit("hit_pulse", ifc.hit, 1);
    lit("hit_y", ifc.ball_y, 432);
    lit("hit_x", ifc.ball_x, 84);
    cycle(0, 0);
    lit("hit_clear", ifc.hit, 0);
    frames(1);
    lit("post_hit_x", ifc.ball_x, 86);
    lit("post_hit_y", ifc.ball_y, 430);

    ifc.paddle_x = 16'd500;
    wait_miss("miss1");
    lit("miss1_lives", ifc.lives, 2);
    lit("miss1_x", ifc.ball_x, 278);
    lit("miss1_y", ifc.ball_y, 470);
    cycle(0, 0);
    lit("miss1_clear", ifc.miss, 0);
    repeat (59) begin cycle(1, 0); cycle(0, 1); end
    lit("miss_wait_x", ifc.ball_x, 278);
    lit("miss_wait_y", ifc.ball_y, 470);
    cycle(1, 0);
    cycle(0, 0);
    lit("reserve_x", ifc.ball_x, 528);
    lit("reserve_y", ifc.ball_y, 432);

    ifc.paddle_x = 16'd100; ifc.paddle_y = 16'd40;
    cycle(0, 0);
    lit("park2_x", ifc.ball_x, 128);
    lit("park2_y", ifc.ball_y, 32);
    cycle(0, 1);
    ifc.paddle_x = 16'd500;
    wait_miss("miss2");
    lit("miss2_lives", ifc.lives, 1);
    frames(60);
    ifc.paddle_x = 16'd100;
    cycle(0, 0);
    cycle(0, 1);
    ifc.paddle_x = 16'd500;
    wait_miss("miss3");
    lit("miss3_lives", ifc.lives, 0);
    lit("over_set", ifc.game_over, 1);
    frames(3);
    lit("over_hold", ifc.game_over, 1);
    cycle(0, 1);
    lit("over_clear", ifc.game_over, 0);
    lit("restart_lives", ifc.lives, 3);

    ifc.paddle_x = 16'd288; ifc.paddle_y = 16'd440;
    cycle(0, 0);
    cycle(0, 1);
    frames(5);
    lit("play5_x", ifc.ball_x, 326);
    rst = 1'b1;
    cycle(0, 0);
    lit("midrst_x", ifc.ball_x, 0);
    lit("midrst_y", ifc.ball_y, 0);
    lit("midrst_lives", ifc.lives, 3);
    rst = 1'b0;
    cycle(0, 0);
    lit("midrst_idle_x", ifc.ball_x, 316);
    lit("midrst_idle_y", ifc.ball_y, 432);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
